// File: rtl/hc595_chain_driver.sv
// Serial driver for a chain of 74HC595 registers. It takes one frame over a
// valid/ready handshake, shifts it out on ds/shcp and latches it with stcp.
module hc595_chain_driver #(
   parameter int DATA_W    = 14,
   parameter int DIV       = 2,
   parameter int MSB_FIRST = 0,
   parameter int OE_BLANK  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] frame_data,
   input  logic              frame_valid,
   output logic              frame_ready,
   input  logic              oe_en,
   output logic              stcp,
   output logic              shcp,
   output logic              ds,
   output logic              oe,
   output logic              busy
);

   localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_CW = $clog2(DATA_W);
   localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t              state;
   logic [DIV_CW-1:0]   div_cnt;
   logic [BIT_CW-1:0]   bit_cnt;
   logic [DATA_W-1:0]   sreg;
   logic [DATA_W-1:0]   frame_ord;
   logic                div_wrap;

   assign frame_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign div_wrap    = (div_cnt == DIV_LAST);

   // Reorder the frame so the first bit to send always sits at index 0.
   // NOTE: default assignment first so no path through this block can infer a latch.
   always_comb begin
      frame_ord = frame_data;
      for (int i = 0; i < DATA_W; i++)
         frame_ord[i] = (MSB_FIRST != 0) ? frame_data[DATA_W-1-i] : frame_data[i];
   end

   // NOTE: non-blocking throughout, so oe below sees the state from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         sreg    <= '0;
         stcp    <= 1'b0;
         shcp    <= 1'b0;
         ds      <= 1'b0;
         oe      <= 1'b1;
      end else begin
         oe <= ~(oe_en && !((OE_BLANK != 0) && (state != IDLE)));
         case (state)
            IDLE: begin
               stcp <= 1'b0;
               shcp <= 1'b0;
               ds   <= 1'b0;
               if (frame_valid) begin
                  sreg    <= frame_ord >> 1;
                  ds      <= frame_ord[0];
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
               if (div_wrap) begin
                  if (!shcp) begin
                     shcp <= 1'b1;
                  end else begin
                     // ds only moves on the falling edge, keeping it stable across each rise
                     shcp <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        stcp  <= 1'b1;
                        ds    <= 1'b0;
                        state <= LATCH;
                     end else begin
                        ds      <= sreg[0];
                        sreg    <= sreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            LATCH: begin
               div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
               if (div_wrap) begin
                  stcp  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: three configurations driven with directed and
// random frames, compared against timing/bit-order formulas.
module tb_hc595_chain_driver;

   localparam int W_P  [3] = '{14, 16, 14};
   localparam int DV_P [3] = '{2, 1, 2};
   localparam int MS_P [3] = '{0, 1, 0};

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] fd0;
   logic [15:0] fd1;
   logic [13:0] fd2;
   logic        valid_v [3];
   logic        oe_en_v [3];
   logic        stcp_v  [3];
   logic        shcp_v  [3];
   logic        ds_v    [3];
   logic        oe_v    [3];
   logic        ready_v [3];
   logic        busy_v  [3];

   int n_checks = 0;
   int n_fail   = 0;

   // Records filled by observe()
   bit rise_ds    [$];
   int rise_cyc   [$];
   int stcp_rise  [$];
   int stcp_fall  [$];
   int ready_rise [$];
   int ds_unstable, latch_shcp, oe_cnt, oe_first, oe_last, acc2;

   always #5 clk = ~clk;

   hc595_chain_driver #(.DATA_W(14), .DIV(2), .MSB_FIRST(0), .OE_BLANK(0)) u_def (
      .clk(clk), .rst(rst), .frame_data(fd0), .frame_valid(valid_v[0]),
      .frame_ready(ready_v[0]), .oe_en(oe_en_v[0]), .stcp(stcp_v[0]),
      .shcp(shcp_v[0]), .ds(ds_v[0]), .oe(oe_v[0]), .busy(busy_v[0]));

   hc595_chain_driver #(.DATA_W(16), .DIV(1), .MSB_FIRST(1), .OE_BLANK(0)) u_msb (
      .clk(clk), .rst(rst), .frame_data(fd1), .frame_valid(valid_v[1]),
      .frame_ready(ready_v[1]), .oe_en(oe_en_v[1]), .stcp(stcp_v[1]),
      .shcp(shcp_v[1]), .ds(ds_v[1]), .oe(oe_v[1]), .busy(busy_v[1]));

   hc595_chain_driver #(.DATA_W(14), .DIV(2), .MSB_FIRST(0), .OE_BLANK(1)) u_blank (
      .clk(clk), .rst(rst), .frame_data(fd2), .frame_valid(valid_v[2]),
      .frame_ready(ready_v[2]), .oe_en(oe_en_v[2]), .stcp(stcp_v[2]),
      .shcp(shcp_v[2]), .ds(ds_v[2]), .oe(oe_v[2]), .busy(busy_v[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_data(input int k, input logic [63:0] d);
      case (k)
         0:       fd0 = d[13:0];
         1:       fd1 = d[15:0];
         default: fd2 = d[13:0];
      endcase
   endtask

   // NOTE: inputs are driven with blocking assignments on the falling edge, half a cycle clear of the active edge.
   task automatic start(input int k, input logic [63:0] d);
      @(negedge clk);
      check($sformatf("ready_before_start_%0d", k), ready_v[k], 1);
      set_data(k, d);
      valid_v[k] = 1'b1;
   endtask

   // Cycle n is sampled on the falling edge after the n-th rising edge following accept.
   task automatic observe(input int k, input int cycles, input bit two, input logic [63:0] nxt);
      logic p_shcp, p_stcp, p_ds, p_ready, s_shcp, s_stcp, s_ds, s_ready;
      bit   drop, acc_seen;
      rise_ds.delete(); rise_cyc.delete(); stcp_rise.delete();
      stcp_fall.delete(); ready_rise.delete();
      ds_unstable = 0; latch_shcp = 0; oe_cnt = 0; oe_first = -1; oe_last = -1; acc2 = -1;
      p_shcp = 0; p_stcp = 0; p_ds = 0; p_ready = 0; drop = 0; acc_seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         if (n == 0) begin
            if (two) set_data(k, nxt);
            else     valid_v[k] = 1'b0;
         end
         if (drop) begin
            valid_v[k] = 1'b0;
            drop = 0;
         end
         s_shcp = shcp_v[k]; s_stcp = stcp_v[k]; s_ds = ds_v[k]; s_ready = ready_v[k];
         if (s_shcp && !p_shcp) begin
            rise_ds.push_back(s_ds);
            rise_cyc.push_back(n);
         end
         if (s_shcp && p_shcp && s_ds != p_ds) ds_unstable++;
         if (s_stcp && !p_stcp) stcp_rise.push_back(n);
         if (!s_stcp && p_stcp) stcp_fall.push_back(n);
         if (s_stcp && (s_shcp || (p_stcp && s_shcp != p_shcp))) latch_shcp++;
         if (s_ready && !p_ready) ready_rise.push_back(n);
         if (two && !acc_seen && valid_v[k] && s_ready) begin
            acc2 = n + 1;
            acc_seen = 1;
            drop = 1;
         end
         if (oe_v[k]) begin
            oe_cnt++;
            if (oe_first < 0) oe_first = n;
            oe_last = n;
         end
         p_shcp = s_shcp; p_stcp = s_stcp; p_ds = s_ds; p_ready = s_ready;
      end
   endtask

   // Frame f accepted at cycle e0; its bits start at index base of the rise queues.
   task automatic check_frame(input string tag, input int k, input int f, input int e0,
                              input logic [63:0] d, input int base);
      int w, dv, bad;
      logic [63:0] got, exp;
      w = W_P[k]; dv = DV_P[k];
      got = '0; exp = '0; bad = 0;
      for (int i = 0; i < w; i++) begin
         exp[i] = (MS_P[k] != 0) ? d[w-1-i] : d[i];
         if (base + i < rise_ds.size()) begin
            got[i] = rise_ds[base+i];
            if (rise_cyc[base+i] != e0 + dv + 2*dv*i) bad++;
         end else begin
            bad++;
         end
      end
      check({tag, "_ds_at_rises"}, got, exp);
      check({tag, "_rise_timing_errs"}, bad, 0);
      check({tag, "_stcp_rise"}, (f < stcp_rise.size()) ? stcp_rise[f] : -1, e0 + 2*dv*w);
      check({tag, "_stcp_fall"}, (f < stcp_fall.size()) ? stcp_fall[f] : -1, e0 + 2*dv*w + dv);
      check({tag, "_ready_rise"}, (f < ready_rise.size()) ? ready_rise[f] : -1, e0 + 2*dv*w + dv);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises, stcp_hi, busy_hi, len;
      logic p;
      logic [63:0] d;
      rst = 1'b1;
      fd0 = '0; fd1 = '0; fd2 = '0;
      for (int k = 0; k < 3; k++) begin
         valid_v[k] = 1'b0;
         oe_en_v[k] = 1'b1;
      end

      // Reset values while rst is high
      #1;
      check("rst_stcp", stcp_v[0], 0);
      check("rst_shcp", shcp_v[0], 0);
      check("rst_ds", ds_v[0], 0);
      check("rst_oe", oe_v[0], 1);
      check("rst_ready", ready_v[0], 1);
      check("rst_busy", busy_v[0], 0);
      check("rst_ready_msb", ready_v[1], 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check("oe_before_first_edge", oe_v[0], 1);
      @(negedge clk);
      check("oe_after_release", oe_v[0], 0);

      // Asynchronous assert in mid-idle
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_oe", oe_v[0], 1);
      check("async_rst_ready", ready_v[0], 1);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("oe_after_second_release", oe_v[0], 0);

      // Default configuration, directed frame
      start(0, 14'h2A5F);
      observe(0, 62, 0, 0);
      check_frame("def", 0, 0, 0, 14'h2A5F, 0);
      check("def_rise_count", rise_ds.size(), 14);
      check("def_stcp_pulses", stcp_rise.size(), 1);
      check("def_ds_unstable", ds_unstable, 0);
      check("def_shcp_in_latch", latch_shcp, 0);
      check("def_oe_high_cycles", oe_cnt, 0);

      // MSB-first, DIV=1
      start(1, 16'h8001);
      observe(1, 36, 0, 0);
      check_frame("msb", 1, 0, 0, 16'h8001, 0);
      check("msb_rise_count", rise_ds.size(), 16);
      check("msb_stcp_pulses", stcp_rise.size(), 1);

      // Random frames on both bit orders
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 2; k++) begin
            d = {$urandom(), $urandom()} & ((64'd1 << W_P[k]) - 64'd1);
            len = 2*DV_P[k]*W_P[k] + DV_P[k] + 4;
            start(k, d);
            observe(k, len, 0, 0);
            check_frame($sformatf("rand%0d_%0d", k, r), k, 0, 0, d, 0);
            check($sformatf("rand%0d_%0d_rise_count", k, r), rise_ds.size(), W_P[k]);
            check($sformatf("rand%0d_%0d_ds_unstable", k, r), ds_unstable, 0);
         end
      end

      // Back-to-back with frame_valid held
      start(0, 14'h0001);
      observe(0, 122, 1, 14'h3FFE);
      check("b2b_second_accept", acc2, 59);
      check_frame("b2b0", 0, 0, 0, 14'h0001, 0);
      check_frame("b2b1", 0, 1, 59, 14'h3FFE, 14);
      check("b2b_rise_count", rise_ds.size(), 28);
      check("b2b_stcp_pulses", stcp_rise.size(), 2);
      check("b2b_shcp_in_latch", latch_shcp, 0);

      // Abort after the fifth shcp rise
      start(0, 14'h2AAA);
      rises = 0; p = 1'b0;
      for (int n = 0; n < 100 && rises < 5; n++) begin
         @(negedge clk);
         valid_v[0] = 1'b0;
         if (shcp_v[0] && !p) rises++;
         p = shcp_v[0];
      end
      check("abort_rises_reached", rises, 5);
      #1 rst = 1'b1;
      #1;
      check("abort_stcp", stcp_v[0], 0);
      check("abort_shcp", shcp_v[0], 0);
      check("abort_ds", ds_v[0], 0);
      check("abort_oe", oe_v[0], 1);
      check("abort_ready", ready_v[0], 1);
      @(negedge clk) rst = 1'b0;
      stcp_hi = 0; busy_hi = 0;
      for (int n = 0; n < 62; n++) begin
         @(negedge clk);
         if (stcp_v[0]) stcp_hi++;
         if (busy_v[0]) busy_hi++;
      end
      check("abort_no_stcp", stcp_hi, 0);
      check("abort_stays_idle", busy_hi, 0);
      start(0, 14'h1234);
      observe(0, 62, 0, 0);
      check_frame("after_abort", 0, 0, 0, 14'h1234, 0);
      check("after_abort_rise_count", rise_ds.size(), 14);

      // Output blanking while busy
      d = {$urandom(), $urandom()} & 64'h3FFF;
      start(2, d);
      observe(2, 62, 0, 0);
      check_frame("blank_en", 2, 0, 0, d, 0);
      check("blank_oe_first_high", oe_first, 1);
      check("blank_oe_last_high", oe_last, 58);
      check("blank_oe_high_cycles", oe_cnt, 58);
      oe_en_v[2] = 1'b0;
      repeat (2) @(negedge clk);
      check("blank_oe_disabled_idle", oe_v[2], 1);
      d = {$urandom(), $urandom()} & 64'h3FFF;
      start(2, d);
      observe(2, 62, 0, 0);
      check_frame("blank_dis", 2, 0, 0, d, 0);
      check("blank_dis_oe_high_cycles", oe_cnt, 62);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
